rom_pipe: RTL and testbench



---
 rtl/rom_pipe_pkg.sv | 36 +++
 rtl/rom_pipe_stage.sv | 42 ++++
 rtl/rom_pipe.sv | 100 ++++++++++
 tb/tb_rom_pipe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rom_pipe_pkg.sv
// Shared constants and the content generator for the rom_pipe lookup table.
// rom_word() returns {err, data[63:0]}; callers keep the low DATA_W bits.
package rom_pipe_pkg;

  localparam int ROM_ONEHOT   = 0;
  localparam int ROM_THERMO   = 1;
  localparam int ROM_GRAY     = 2;
  localparam int ROM_IDENTITY = 3;

  localparam int ROM_WORD_W = 64;

  function automatic logic [ROM_WORD_W:0] rom_word(input int mode,
                                                   input int addr,
                                                   input int data_w,
                                                   input int depth);
    logic [ROM_WORD_W-1:0] a_v;
    logic [ROM_WORD_W-1:0] d_v;
    logic [ROM_WORD_W-1:0] mask_v;
    int                    k;
    a_v    = ROM_WORD_W'(addr);
    mask_v = (data_w >= ROM_WORD_W) ? '1 : ((64'd1 << data_w) - 64'd1);
    k      = addr % data_w;
    case (mode)
      ROM_ONEHOT: d_v = 64'd1 << k;
      // k = 63 would shift the 1 out of range, so fill explicitly
      ROM_THERMO: d_v = (k >= ROM_WORD_W - 1) ? '1 : ((64'd1 << (k + 1)) - 64'd1);
      ROM_GRAY:   d_v = a_v ^ (a_v >> 1);
      default:    d_v = a_v;
    endcase
    if (addr >= depth) begin
      return {1'b1, {ROM_WORD_W{1'b0}}};
    end
    return {1'b0, d_v & mask_v};
  endfunction

endpackage

// File: rtl/rom_pipe_stage.sv
// One pipeline slot of rom_pipe: a valid bit plus payload, loaded when en_i
// is high and held otherwise. Reset clears both.
module rom_pipe_stage #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic         valid_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (en_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/rom_pipe.sv
// Pipelined constant lookup table with valid/ready on both sides.
// All stages advance together whenever the output slot is empty or being taken.
module rom_pipe
  import rom_pipe_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int MODE    = 0,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  rd_count
);

  localparam int PW      = DATA_W + 1;
  localparam int N_WORDS = 2 ** ADDR_W;

  if (DEPTH < 1 || DEPTH > N_WORDS) begin : g_bad_depth
    $fatal(1, "rom_pipe: DEPTH must be in 1..2**ADDR_W");
  end
  if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
    $fatal(1, "rom_pipe: LATENCY must be 1 or 2");
  end
  if (MODE < ROM_ONEHOT || MODE > ROM_IDENTITY) begin : g_bad_mode
    $fatal(1, "rom_pipe: illegal MODE");
  end
  if (DATA_W < 1 || DATA_W > ROM_WORD_W) begin : g_bad_width
    $fatal(1, "rom_pipe: DATA_W must be in 1..64");
  end

  // Content is fixed at elaboration; every address slot, including the
  // out-of-range ones, gets its {err, data} word here.
  logic [PW-1:0] rom_tbl [N_WORDS];

  for (genvar i = 0; i < N_WORDS; i++) begin : g_rom
    localparam logic [ROM_WORD_W:0] WORD_I = rom_word(MODE, i, DATA_W, DEPTH);
    assign rom_tbl[i] = {WORD_I[ROM_WORD_W], WORD_I[DATA_W-1:0]};
  end

  logic advance;
  logic accept;

  assign advance   = !rsp_valid || rsp_ready;
  assign req_ready = advance;
  assign accept    = req_valid && advance;

  logic [LATENCY:0] vld_c;
  logic [PW-1:0]    pay_c [LATENCY+1];

  assign vld_c[0] = accept;
  assign pay_c[0] = accept ? rom_tbl[req_addr] : '0;

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    rom_pipe_stage #(
      .W(PW)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en_i    (advance),
      .valid_i (vld_c[s]),
      .data_i  (pay_c[s]),
      .valid_o (vld_c[s+1]),
      .data_o  (pay_c[s+1])
    );
  end

  assign rsp_valid           = vld_c[LATENCY];
  assign {rsp_err, rsp_data} = pay_c[LATENCY];

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rd_count = cnt_q;

endmodule

// File: tb/tb_rom_pipe.sv
// Directed bench for rom_pipe: several parameterisations share clock and reset,
// each exercised with hand-computed vectors.
module tb_rom_pipe;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // u0: defaults, ONEHOT 16x16, LATENCY 1
  logic v0, rr0, rdy0, rv0, er0;
  logic [3:0]  a0;
  logic [15:0] d0;
  logic [15:0] c0;
  rom_pipe u0 (.clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_addr(a0),
               .rsp_valid(rv0), .rsp_ready(rr0), .rsp_data(d0), .rsp_err(er0), .rd_count(c0));

  // u1: THERMO
  logic v1, rr1, rdy1, rv1, er1;
  logic [3:0]  a1;
  logic [15:0] d1;
  logic [15:0] c1;
  rom_pipe #(.MODE(1)) u1 (.clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1), .req_addr(a1),
               .rsp_valid(rv1), .rsp_ready(rr1), .rsp_data(d1), .rsp_err(er1), .rd_count(c1));

  // u2: GRAY
  logic v2, rr2, rdy2, rv2, er2;
  logic [3:0]  a2;
  logic [15:0] d2;
  logic [15:0] c2;
  rom_pipe #(.MODE(2)) u2 (.clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_addr(a2),
               .rsp_valid(rv2), .rsp_ready(rr2), .rsp_data(d2), .rsp_err(er2), .rd_count(c2));

  // u3: IDENTITY, 8-bit words, 1024 entries
  logic v3, rr3, rdy3, rv3, er3;
  logic [9:0]  a3;
  logic [7:0]  d3;
  logic [15:0] c3;
  rom_pipe #(.MODE(3), .DATA_W(8), .ADDR_W(10), .DEPTH(1024)) u3 (
               .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_addr(a3),
               .rsp_valid(rv3), .rsp_ready(rr3), .rsp_data(d3), .rsp_err(er3), .rd_count(c3));

  // u4: DEPTH 12
  logic v4, rr4, rdy4, rv4, er4;
  logic [3:0]  a4;
  logic [15:0] d4;
  logic [15:0] c4;
  rom_pipe #(.DEPTH(12)) u4 (.clk(clk), .rst(rst), .req_valid(v4), .req_ready(rdy4), .req_addr(a4),
               .rsp_valid(rv4), .rsp_ready(rr4), .rsp_data(d4), .rsp_err(er4), .rd_count(c4));

  // u5: LATENCY 2
  logic v5, rr5, rdy5, rv5, er5;
  logic [3:0]  a5;
  logic [15:0] d5;
  logic [15:0] c5;
  rom_pipe #(.LATENCY(2)) u5 (.clk(clk), .rst(rst), .req_valid(v5), .req_ready(rdy5), .req_addr(a5),
               .rsp_valid(rv5), .rsp_ready(rr5), .rsp_data(d5), .rsp_err(er5), .rd_count(c5));

  // u6: 3-bit counter
  logic v6, rr6, rdy6, rv6, er6;
  logic [3:0]  a6;
  logic [15:0] d6;
  logic [2:0]  c6;
  rom_pipe #(.CNT_W(3)) u6 (.clk(clk), .rst(rst), .req_valid(v6), .req_ready(rdy6), .req_addr(a6),
               .rsp_valid(rv6), .rsp_ready(rr6), .rsp_data(d6), .rsp_err(er6), .rd_count(c6));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nxt;
    int got_idx;
    int first_c;
    n_chk = 0;
    n_err = 0;
    {v0, v1, v2, v3, v4, v5, v6} = '0;
    {rr0, rr1, rr2, rr3, rr4, rr5, rr6} = '1;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0; a4 = '0; a5 = '0; a6 = '0;
    rst = 1'b1;

    // reset state
    #12;
    chk("rst_rsp_valid", 64'(rv0), 64'd0);
    chk("rst_rsp_data", 64'(d0), 64'd0);
    chk("rst_rsp_err", 64'(er0), 64'd0);
    chk("rst_rd_count", 64'(c0), 64'd0);
    chk("rst_req_ready", 64'(rdy0), 64'd1);
    chk("rst_l2_valid", 64'(rv5), 64'd0);
    step();
    rst = 1'b0;
    step();

    // ONEHOT streaming 0..15, one response per cycle, one cycle after request
    v0 = 1'b1;
    a0 = 4'd0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("onehot_valid", 64'(rv0), 64'd1);
      chk("onehot_data", 64'(d0), 64'd1 << i);
      chk("onehot_err", 64'(er0), 64'd0);
      if (i == 15) v0 = 1'b0;
      else a0 = 4'(i + 1);
    end
    step();
    chk("onehot_drain", 64'(rv0), 64'd0);
    chk("onehot_count", 64'(c0), 64'd16);

    // content modes and out-of-range detection
    v1 = 1'b1; a1 = 4'd3;
    v2 = 1'b1; a2 = 4'd10;
    v3 = 1'b1; a3 = 10'h1A5;
    v4 = 1'b1; a4 = 4'd13;
    step();
    v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    a4 = 4'd11;
    chk("thermo_data", 64'(d1), 64'h000F);
    chk("thermo_valid", 64'(rv1), 64'd1);
    chk("gray_data", 64'(d2), 64'h000F);
    chk("ident_data", 64'(d3), 64'hA5);
    chk("ident_err", 64'(er3), 64'd0);
    chk("oor_data", 64'(d4), 64'd0);
    chk("oor_err", 64'(er4), 64'd1);
    chk("oor_valid", 64'(rv4), 64'd1);
    step();
    v4 = 1'b0;
    chk("inr_data", 64'(d4), 64'h0800);
    chk("inr_err", 64'(er4), 64'd0);
    chk("oor_count", 64'(c4), 64'd2);

    // LATENCY 2 streaming with a 3-cycle stall
    nxt = 0;
    got_idx = 0;
    first_c = -1;
    for (int c = 0; c < 24; c++) begin
      rr5 = !(c >= 4 && c <= 6);
      v5 = (nxt < 10);
      a5 = 4'(nxt);
      #1;
      if (rv5) begin
        if (first_c < 0) first_c = c;
        chk("l2_data", 64'(d5), 64'd1 << got_idx);
        chk("l2_err", 64'(er5), 64'd0);
        if (rr5) got_idx++;
      end
      chk("l2_req_ready", 64'(rdy5), (rv5 && !rr5) ? 64'd0 : 64'd1);
      if (v5 && rdy5) nxt++;
      step();
    end
    v5 = 1'b0;
    rr5 = 1'b1;
    chk("l2_first_latency", 64'(first_c), 64'd2);
    chk("l2_all_received", 64'(got_idx), 64'd10);
    chk("l2_no_extra", 64'(rv5), 64'd0);
    chk("l2_count", 64'(c5), 64'd10);

    // saturating 3-bit counter
    v6 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a6 = 4'(i);
      step();
      chk("sat_count", 64'(c6), (i + 1 > 7) ? 64'd7 : 64'(i + 1));
    end
    v6 = 1'b0;
    step();
    chk("sat_hold", 64'(c6), 64'd7);

    // reset with two responses in flight on the LATENCY 2 instance
    v5 = 1'b1;
    a5 = 4'd5;
    step();
    a5 = 4'd6;
    step();
    v5 = 1'b0;
    chk("inflight_valid", 64'(rv5), 64'd1);
    chk("inflight_data", 64'(d5), 64'h0020);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(rv5), 64'd0);
    chk("midrst_count", 64'(c5), 64'd0);
    chk("midrst_data", 64'(d5), 64'd0);
    chk("midrst_ready", 64'(rdy5), 64'd1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("postrst_no_stale", 64'(rv5), 64'd0);
    end
    chk("postrst_count", 64'(c5), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got 0x0 expected 0x1");
    $fatal(1, "timeout");
  end

endmodule
